hdcpu_beat_gen: RTL and testbench
=================================

# hdcpu_beat_gen

Beat and phase timing generator for the HDCPU hardwired controller. Divides the system clock into T1/T2/T3 phases and sequences the W1/W2/W3 machine beats. Beat length follows the controller's SHORT/LONG requests, and execution halts on STOP. A synchronized panel start button (QD) resumes execution. Sits directly upstream of the controller: its W[3:1] and T3 outputs are the controller's timing inputs, and the controller's SHORT/LONG/STOP outputs feed back into it.

## Interface
- No parameters.
- CLK  input  1  system clock; all state changes on rising edge.
- CLR  input  1  reset, asynchronous, active-low.
- QD  input  1  panel start button, asynchronous level, already debounced.
- SHORT  input  1  from controller: current W1 is the last beat.
- LONG  input  1  from controller: extend from W2 into W3.
- STOP  input  1  from controller: halt at the end of the current beat.
- T  output  3  one-hot phase: T[1], T[2], T[3]; all zero while halted.
- W  output  3  one-hot beat: W[1], W[2], W[3]; never all zero.
- RUN  output  1  high while phases are being generated.

## Operation
- Reset (CLR low) sets T=3'b000, W=3'b001, RUN=0, and clears the synchronizer and phase counter.
- Two states: HALT and RUN.
- HALT
  - T=000 and W holds the beat to be executed on resume.
  - A qualified QD rising edge moves to RUN with T=001.
- RUN: T rotates T1→T2→T3→T1, one CLK cycle per phase.
- Beat boundary is the rising edge that leaves T3. At that edge, SHORT/LONG/STOP are sampled and the next W is chosen:
  - W1: SHORT=1 → W1, else W2.
  - W2: LONG=1 → W3, else W1.
  - W3: always W1.
  - SHORT is ignored outside W1. LONG is ignored outside W2.
- STOP=1 at a beat boundary:
  - W still advances per the rules above.
  - The state goes to HALT, RUN=0 and T=000 from that edge.
- STOP is ignored outside the boundary edge.
- QD edges while in RUN are discarded. They are not queued.
- If STOP and a QD rising edge coincide at a boundary, STOP wins. That QD edge is discarded.

## Timing
- QD path: two-flop synchronizer plus a third flop for edge detect.
  - If QD is first sampled high at edge n, RUN=1 and T=001 from edge n+2.
- A phase is exactly 1 CLK. A beat is exactly 3 CLK.
  - Instruction length is 3 CLK (short), 6 CLK (normal) or 9 CLK (long).
- W changes only at the T3→T1 edge, so W is stable across all three phases of a beat.
- All outputs are registered and glitch-free. T3 falls at the same edge W advances.
- CLR low mid-beat returns to the reset values immediately. There is no partial-beat completion.

## Configuration
- HDCPU_STEP_EN
  - Defined: adds input STEP (1 bit). When STEP=1, the block also halts at any boundary where the next W is W1, giving single-instruction stepping. QD then runs one full instruction per press.
  - Undefined: no STEP port, and only STOP halts.

## Structure
- Shared package hdcpu_pkg:
  - one-hot constants W_1/W_2/W_3 and PH_T1/PH_T2/PH_T3;
  - state enum {ST_HALT, ST_RUN}.
- Sub-module qd_sync: 2-flop synchronizer plus rising-edge pulse, with async active-low clear.

## Test plan
- Reset:
  - Hold CLR=0 for 3 cycles then release → T=000, W=001, RUN=0.
  - Pulse QD high → T=001 appears 2 edges after QD is first sampled, then T rotates 001→010→100.
- Normal instruction: SHORT=0, LONG=0 → W sequence 001,010,001 each held 3 CLK. An instruction is 6 CLK.
- Long instruction: LONG=1 during W2 → W 001→010→100→001. Short instruction: SHORT=1 during W1 → W stays 001 for consecutive beats.
- STOP=1 during W2 with LONG=1 → after the boundary RUN=0, T=000, W=100. The next QD press resumes in W3 with T=001.
- Coincident events:
  - QD pressed while RUN=1 → no effect.
  - STOP with QD edge on the same boundary → halted.
  - CLR pulsed low during T2 of W3 → immediate T=000, W=001, RUN=0.
- With HDCPU_STEP_EN and STEP=1: each QD press runs exactly one instruction (6 CLK normal), then halts with W=001.

Source files
------------

// File: rtl/hdcpu_pkg.sv
// Shared timing definitions for the HDCPU hardwired controller: one-hot beat
// and phase encodings, the beat-generator state type and the beat sequencing rule.
package hdcpu_pkg;

  localparam logic [2:0] W_1    = 3'b001;
  localparam logic [2:0] W_2    = 3'b010;
  localparam logic [2:0] W_3    = 3'b100;

  localparam logic [2:0] PH_OFF = 3'b000;
  localparam logic [2:0] PH_T1  = 3'b001;
  localparam logic [2:0] PH_T2  = 3'b010;
  localparam logic [2:0] PH_T3  = 3'b100;

  typedef enum logic {ST_HALT, ST_RUN} state_t;

  // Beat that follows the current one: SHORT only matters in W1, LONG only in W2.
  function automatic logic [2:0] next_beat(input logic [2:0] w,
                                           input logic       short_req,
                                           input logic       long_req);
    logic [2:0] nb;
    nb = W_1;
    case (w)
      W_1:     nb = short_req ? W_1 : W_2;
      W_2:     nb = long_req  ? W_3 : W_1;
      default: nb = W_1;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/hdcpu_beat_gen_qd_sync.sv
// Panel start button synchronizer: two flops into the CLK domain plus a third
// flop so that a level press becomes a single-cycle rising-edge pulse.
module qd_sync (
  input  logic CLK,
  input  logic CLR,
  input  logic QD,
  output logic QD_RISE
);

  logic meta, sync, sync_d;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make this a true shift chain; blocking
      // ones would collapse the three flops into one.
      meta   <= QD;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign QD_RISE = sync & ~sync_d;

endmodule

// File: rtl/hdcpu_beat_gen.sv
// HDCPU beat/phase generator: T1/T2/T3 phases, W1/W2/W3 beats, STOP halt and
// QD resume. Optional single-instruction stepping under macro HDCPU_STEP_EN.
module hdcpu_beat_gen
  import hdcpu_pkg::*;
(
  input  logic       CLK,
  input  logic       CLR,
  input  logic       QD,
  input  logic       SHORT,
  input  logic       LONG,
  input  logic       STOP,
`ifdef HDCPU_STEP_EN
  input  logic       STEP,
`endif
  output logic [2:0] T,
  output logic [2:0] W,
  output logic       RUN
);

  state_t     state, state_nx;
  logic [2:0] t_q, t_nx;
  logic [2:0] w_q, w_nx;
  logic       qd_rise;
  logic       halt_req;

  qd_sync u_qd_sync (
    .CLK     (CLK),
    .CLR     (CLR),
    .QD      (QD),
    .QD_RISE (qd_rise)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= ST_HALT;
      t_q   <= PH_OFF;
      w_q   <= W_1;
    end else begin
      state <= state_nx;
      t_q   <= t_nx;
      w_q   <= w_nx;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_nx = state;
    t_nx     = t_q;
    w_nx     = w_q;
    halt_req = 1'b0;
    case (state)
      ST_HALT: begin
        t_nx = PH_OFF;
        if (qd_rise) begin
          state_nx = ST_RUN;
          t_nx     = PH_T1;
        end
      end
      default: begin
        // QD pulses are simply not looked at while running.
        if (t_q == PH_T3) begin
          w_nx     = next_beat(w_q, SHORT, LONG);
          halt_req = STOP;
`ifdef HDCPU_STEP_EN
          if (STEP && (w_nx == W_1)) halt_req = 1'b1;
`endif
          if (halt_req) begin
            state_nx = ST_HALT;
            t_nx     = PH_OFF;
          end else begin
            t_nx     = PH_T1;
          end
        end else begin
          t_nx = {t_q[1:0], 1'b0};
        end
      end
    endcase
  end

  assign T   = t_q;
  assign W   = w_q;
  assign RUN = (state == ST_RUN);

endmodule

// File: tb/tb_hdcpu_beat_gen.sv
// Self-checking bench for hdcpu_beat_gen: per-cycle vector tables through a
// scoreboard queue, plus hand-written reset, async-clear and QD latency sequences.
module tb_hdcpu_beat_gen;

  typedef struct {
    logic       qd;
    logic       sh;
    logic       lg;
    logic       st;
    logic [6:0] exp;   // {T, W, RUN}
  } vec_t;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       QD = 1'b0, SHORT = 1'b0, LONG = 1'b0, STOP = 1'b0;
  logic [2:0] T, W;
  logic       RUN;
`ifdef HDCPU_STEP_EN
  logic       STEP = 1'b0;
`endif

  vec_t       tbl[$];
  logic [6:0] sb[$];
  int         n_vec = 0;
  int         n_bad = 0;

  hdcpu_beat_gen dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .QD    (QD),
    .SHORT (SHORT),
    .LONG  (LONG),
    .STOP  (STOP),
`ifdef HDCPU_STEP_EN
    .STEP  (STEP),
`endif
    .T     (T),
    .W     (W),
    .RUN   (RUN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got T=%b W=%b RUN=%b, want T=%b W=%b RUN=%b",
               name, act[6:4], act[3:1], act[0], exp[6:4], exp[3:1], exp[0]);
    end
  endtask

  task automatic add(input logic qd, input logic sh, input logic lg, input logic st,
                     input logic [2:0] t, input logic [2:0] w, input logic run);
    vec_t v;
    v.qd = qd; v.sh = sh; v.lg = lg; v.st = st;
    v.exp = {t, w, run};
    tbl.push_back(v);
  endtask

  // Drive each record before an edge, push its expectation, compare after the edge.
  task automatic run_table(input string tag);
    logic [6:0] e;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      QD = tbl[i].qd; SHORT = tbl[i].sh; LONG = tbl[i].lg; STOP = tbl[i].st;
      sb.push_back(tbl[i].exp);
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      check($sformatf("%s[%0d]", tag, i), {T, W, RUN}, e);
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    CLR = 1'b0; QD = 1'b0; SHORT = 1'b0; LONG = 1'b0; STOP = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    CLR = 1'b1;
  endtask

  initial begin
    int edges;

    // Reset held 3 cycles, then released.
    repeat (3) @(posedge CLK);
    #1 check("in_reset", {T, W, RUN}, 7'b000_001_0);
    @(negedge CLK) CLR = 1'b1;
    @(posedge CLK);
    #1 check("after_reset", {T, W, RUN}, 7'b000_001_0);

    // qd sh lg st  T       W       RUN
    add(1, 0, 0, 0, 3'b000, 3'b001, 0);  // 0 QD first sampled
    add(1, 0, 0, 0, 3'b000, 3'b001, 0);  // 1
    add(1, 0, 0, 0, 3'b001, 3'b001, 1);  // 2 run starts two edges later
    add(0, 0, 0, 0, 3'b010, 3'b001, 1);  // 3
    add(0, 0, 0, 0, 3'b100, 3'b001, 1);  // 4
    add(0, 0, 1, 0, 3'b001, 3'b010, 1);  // 5 W1->W2, LONG ignored in W1
    add(1, 0, 0, 0, 3'b010, 3'b010, 1);  // 6 QD press during run
    add(1, 0, 0, 0, 3'b100, 3'b010, 1);  // 7
    add(1, 1, 0, 0, 3'b001, 3'b001, 1);  // 8 W2->W1, SHORT ignored in W2
    add(0, 0, 0, 0, 3'b010, 3'b001, 1);  // 9 discarded QD changes nothing
    add(0, 0, 0, 0, 3'b100, 3'b001, 1);  // 10
    add(0, 1, 0, 0, 3'b001, 3'b001, 1);  // 11 short: W1 again
    add(0, 0, 0, 0, 3'b010, 3'b001, 1);  // 12
    add(0, 0, 0, 0, 3'b100, 3'b001, 1);  // 13
    add(0, 0, 0, 0, 3'b001, 3'b010, 1);  // 14
    add(0, 0, 0, 0, 3'b010, 3'b010, 1);  // 15
    add(0, 0, 0, 0, 3'b100, 3'b010, 1);  // 16
    add(0, 0, 1, 0, 3'b001, 3'b100, 1);  // 17 long: W3
    add(0, 0, 0, 1, 3'b010, 3'b100, 1);  // 18 STOP off-boundary ignored
    add(0, 0, 0, 1, 3'b100, 3'b100, 1);  // 19
    add(0, 1, 1, 0, 3'b001, 3'b001, 1);  // 20 W3 always W1
    add(0, 0, 0, 0, 3'b010, 3'b001, 1);  // 21
    add(0, 0, 0, 0, 3'b100, 3'b001, 1);  // 22
    add(0, 0, 0, 0, 3'b001, 3'b010, 1);  // 23
    add(0, 0, 0, 0, 3'b010, 3'b010, 1);  // 24
    add(0, 0, 0, 0, 3'b100, 3'b010, 1);  // 25
    add(0, 0, 1, 1, 3'b000, 3'b100, 0);  // 26 STOP+LONG: halt in W3
    add(0, 0, 0, 0, 3'b000, 3'b100, 0);  // 27
    add(1, 0, 0, 0, 3'b000, 3'b100, 0);  // 28
    add(1, 0, 0, 0, 3'b000, 3'b100, 0);  // 29
    add(1, 0, 0, 0, 3'b001, 3'b100, 1);  // 30 resume in W3
    add(0, 0, 0, 0, 3'b010, 3'b100, 1);  // 31
    add(0, 0, 0, 0, 3'b100, 3'b100, 1);  // 32
    add(0, 0, 0, 0, 3'b001, 3'b001, 1);  // 33
    add(1, 0, 0, 0, 3'b010, 3'b001, 1);  // 34 QD timed to pulse at boundary
    add(1, 0, 0, 0, 3'b100, 3'b001, 1);  // 35
    add(1, 0, 0, 1, 3'b000, 3'b010, 0);  // 36 STOP wins over QD
    add(1, 0, 0, 0, 3'b000, 3'b010, 0);  // 37
    add(0, 0, 0, 0, 3'b000, 3'b010, 0);  // 38
    add(0, 0, 0, 0, 3'b000, 3'b010, 0);  // 39
    add(1, 0, 0, 0, 3'b000, 3'b010, 0);  // 40
    add(1, 0, 0, 0, 3'b000, 3'b010, 0);  // 41
    add(0, 0, 0, 0, 3'b001, 3'b010, 1);  // 42 resume in W2
    add(0, 0, 0, 0, 3'b010, 3'b010, 1);  // 43
    add(0, 0, 0, 0, 3'b100, 3'b010, 1);  // 44
    add(0, 0, 1, 0, 3'b001, 3'b100, 1);  // 45
    add(0, 0, 0, 0, 3'b010, 3'b100, 1);  // 46 T2 of W3
    run_table("main");

    // Asynchronous clear in T2 of W3, between clock edges.
    #2 CLR = 1'b0;
    #1 check("clr_mid_beat", {T, W, RUN}, 7'b000_001_0);
    @(negedge CLK) CLR = 1'b1;
    @(posedge CLK);
    #1 check("clr_released", {T, W, RUN}, 7'b000_001_0);

    // Single-cycle QD pulse: RUN must rise exactly two edges after the sampling edge.
    @(negedge CLK) QD = 1'b1;
    @(posedge CLK);
    @(negedge CLK) QD = 1'b0;
    edges = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1 edges++;
      if (RUN) break;
    end
    check("qd_latency", {T, W, RUN, 1'b0, 3'(edges)}, {7'b001_001_1, 1'b0, 3'd2});

`ifdef HDCPU_STEP_EN
    do_reset();
    STEP = 1'b1;
    for (int k = 0; k < 2; k++) begin
      add(1, 0, 0, 0, 3'b000, 3'b001, 0);
      add(1, 0, 0, 0, 3'b000, 3'b001, 0);
      add(0, 0, 0, 0, 3'b001, 3'b001, 1);
      add(0, 0, 0, 0, 3'b010, 3'b001, 1);
      add(0, 0, 0, 0, 3'b100, 3'b001, 1);
      add(0, 0, 0, 0, 3'b001, 3'b010, 1);
      add(0, 0, 0, 0, 3'b010, 3'b010, 1);
      add(0, 0, 0, 0, 3'b100, 3'b010, 1);
      add(0, 0, 0, 0, 3'b000, 3'b001, 0);  // one instruction, then halt
      add(0, 0, 0, 0, 3'b000, 3'b001, 0);
      run_table($sformatf("step%0d", k));
    end
    STEP = 1'b0;
`endif

    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard stop in case a wait above ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want completion before 100000");
    $fatal(1, "timeout");
  end

endmodule
